// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch-stage program-counter generator. Sequential fetch,
//               stall hold, branch/jump redirect with alignment check,
//               trap entry with EPC/MTVAL capture, mret return and a
//               debug halt/resume state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          IALIGN       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            mret_valid,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] mtval,
    output logic            misalign,
    output logic            halted
);

    // Only 2-byte (compressed) and 4-byte instruction alignment exist.
    generate
        if (IALIGN != 2 && IALIGN != 4) begin : g_bad_ialign
            $error("pc_gen: IALIGN must be 2 or 4");
        end
    endgenerate

    localparam int            c_ALIGN_BITS = (IALIGN == 4) ? 2 : 1;
    localparam logic [XLEN-1:0] c_INC      = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] c_RESET_PC = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0] c_TRAP_PC  = XLEN'(TRAP_VECTOR);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_mtval;
    logic            r_pc_valid;
    logic            r_flush;
    logic            r_misalign;
    logic            r_halted;

    logic [XLEN-1:0] w_pc_plus;
    logic            w_target_misaligned;

    // Sequential increment wraps modulo 2^XLEN; target low bits flag misalignment.
    always_comb begin
        w_pc_plus           = r_pc + c_INC;
        w_target_misaligned = (redirect_target[c_ALIGN_BITS-1:0] != '0);
    end

    // Control FSM and next-pc selection; flush/misalign default to a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= c_RESET_PC;
            r_epc      <= '0;
            r_mtval    <= '0;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    if (trap_valid) begin
                        r_pc    <= c_TRAP_PC;
                        r_epc   <= r_pc;
                        r_mtval <= '0;
                        r_flush <= 1'b1;
                    end else if (redirect_valid && w_target_misaligned) begin
                        // A misaligned target is converted into a trap.
                        r_pc       <= c_TRAP_PC;
                        r_epc      <= r_pc;
                        r_mtval    <= redirect_target;
                        r_misalign <= 1'b1;
                        r_flush    <= 1'b1;
                    end else if (mret_valid) begin
                        r_pc    <= r_epc;
                        r_flush <= 1'b1;
                    end else if (redirect_valid) begin
                        r_pc    <= redirect_target;
                        r_flush <= 1'b1;
                    end else if (halt_req) begin
                        r_state    <= S_HALTED;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                    end else if (!stall) begin
                        r_pc <= w_pc_plus;
                    end
                end
                S_HALTED: begin
                    // Redirect and mret are ignored while halted; a trap wakes the core.
                    if (trap_valid) begin
                        r_pc       <= c_TRAP_PC;
                        r_epc      <= r_pc;
                        r_mtval    <= '0;
                        r_flush    <= 1'b1;
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                    end else if (resume) begin
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus  = w_pc_plus;
    assign pc_valid = r_pc_valid;
    assign flush    = r_flush;
    assign epc      = r_epc;
    assign mtval    = r_mtval;
    assign misalign = r_misalign;
    assign halted   = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Directed scoreboard bench for pc_gen. A driver issues one
//               cycle of stimulus at a time and queues the hand-computed
//               outputs; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        mret_valid;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pc_valid;
    logic        flush;
    logic [31:0] epc;
    logic [31:0] mtval;
    logic        misalign;
    logic        halted;

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .IALIGN      (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap_valid     (trap_valid),
        .mret_valid     (mret_valid),
        .halt_req       (halt_req),
        .resume         (resume),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .epc            (epc),
        .mtval          (mtval),
        .misalign       (misalign),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] mtval;
        logic        v;
        logic        fl;
        logic        mis;
        logic        hl;
    } exp_t;

    exp_t        sb[$];
    int          cyc_cnt  = 0;
    int          n_cmp    = 0;
    int          n_fail   = 0;
    logic [31:0] e_epc    = 32'h0;
    logic [31:0] e_mtval  = 32'h0;
    logic        drv_done = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare the entry expected for the cycle that just began.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
            exp_t m;
            m = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", m.name, m.cyc, cyc_cnt);
        end else if (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
            exp_t e;
            logic [31:0] e_plus;
            e = sb.pop_front();
            e_plus = e.pc + 32'd4;
            n_cmp++;
            if (pc !== e.pc || pc_plus !== e_plus || pc_valid !== e.v || flush !== e.fl ||
                misalign !== e.mis || halted !== e.hl || epc !== e.epc || mtval !== e.mtval) begin
                n_fail++;
                $display("FAIL %s: got pc=%h plus=%h v=%b fl=%b mis=%b h=%b epc=%h mtval=%h ; want pc=%h plus=%h v=%b fl=%b mis=%b h=%b epc=%h mtval=%h",
                         e.name, pc, pc_plus, pc_valid, flush, misalign, halted, epc, mtval,
                         e.pc, e_plus, e.v, e.fl, e.mis, e.hl, e.epc, e.mtval);
            end
        end
    end

    // Queue the outputs expected after the next rising edge, step one cycle, clear inputs.
    task automatic step(input string name, input logic [31:0] xpc, input logic xv,
                        input logic xfl, input logic xmis, input logic xhl);
        exp_t e;
        e.cyc   = cyc_cnt + 1;
        e.name  = name;
        e.pc    = xpc;
        e.epc   = e_epc;
        e.mtval = e_mtval;
        e.v     = xv;
        e.fl    = xfl;
        e.mis   = xmis;
        e.hl    = xhl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_valid      = 1'b0;
        mret_valid      = 1'b0;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        trap_valid = 1'b0; mret_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
        @(posedge clk); #1;

        // Reset state / BOOT
        step("reset", 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        step("boot_run0", 32'h0, 1, 0, 0, 0);
        step("seq4", 32'h4, 1, 0, 0, 0);
        step("seq8", 32'h8, 1, 0, 0, 0);
        step("seqC", 32'hC, 1, 0, 0, 0);
        step("seq10", 32'h10, 1, 0, 0, 0);

        // Stall hold then redirect under stall
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            step("stall_hold", 32'h10, 1, 0, 0, 0);
        end
        stall = 1'b1; redirect(32'h200);
        step("redir_over_stall", 32'h200, 1, 1, 0, 0);
        step("after_redir", 32'h204, 1, 0, 0, 0);

        // Misaligned redirect becomes a trap
        redirect(32'h40);
        step("redir40", 32'h40, 1, 1, 0, 0);
        redirect(32'h202); e_epc = 32'h40; e_mtval = 32'h202;
        step("misalign_trap", 32'h100, 1, 1, 1, 0);
        step("after_misalign", 32'h104, 1, 0, 0, 0);

        // Trap beats redirect, then mret returns to epc
        redirect(32'h80);
        step("redir80", 32'h80, 1, 1, 0, 0);
        trap_valid = 1'b1; redirect(32'h300); e_epc = 32'h80; e_mtval = 32'h0;
        step("trap_over_redir", 32'h100, 1, 1, 0, 0);
        step("trap_seq", 32'h104, 1, 0, 0, 0);
        mret_valid = 1'b1;
        step("mret", 32'h80, 1, 1, 0, 0);
        step("after_mret", 32'h84, 1, 0, 0, 0);

        // Halt concurrent with redirect: redirect first, halt on a later cycle
        halt_req = 1'b1; redirect(32'h20);
        step("halt_with_redir", 32'h20, 1, 1, 0, 0);
        halt_req = 1'b1;
        step("halt_enter", 32'h20, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("halt_hold", 32'h20, 0, 0, 0, 1);
        redirect(32'h400); mret_valid = 1'b1;
        step("halt_ignore", 32'h20, 0, 0, 0, 1);
        resume = 1'b1;
        step("resume", 32'h20, 1, 0, 0, 0);
        step("after_resume", 32'h24, 1, 0, 0, 0);

        // Trap while halted wakes the core
        halt_req = 1'b1;
        step("halt2", 32'h24, 0, 0, 0, 1);
        trap_valid = 1'b1; e_epc = 32'h24; e_mtval = 32'h0;
        step("trap_from_halt", 32'h100, 1, 1, 0, 0);
        step("after_halt_trap", 32'h104, 1, 0, 0, 0);

        // Wraparound at top of address space
        redirect(32'hFFFF_FFF8);
        step("redir_top", 32'hFFFF_FFF8, 1, 1, 0, 0);
        step("top_plus", 32'hFFFF_FFFC, 1, 0, 0, 0);
        step("wrap0", 32'h0, 1, 0, 0, 0);

        // Reset mid-run
        reset = 1'b1; e_epc = 32'h0; e_mtval = 32'h0;
        step("midrun_reset", 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        step("post_reset_run", 32'h0, 1, 0, 0, 0);
        step("post_reset_seq", 32'h4, 1, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        drv_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Time-limit guard so the run always terminates.
    initial begin
        #50000;
        if (!drv_done) begin
            $display("FAIL timeout: bench did not complete, compared=%0d", n_cmp);
            $fatal(1, "timeout");
        end
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the RISC-V pipeline fetch stage. It extends the plain PC register with a configurable reset vector, stall hold, and branch/jump redirect. It also adds trap entry with EPC capture, mret return, target-alignment checking, and a halt/resume state machine. It drives the instruction-memory address and the IF/ID fetch-valid qualifier.

Parameters:
XLEN, 32, PC/address width in bits
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
TRAP_VECTOR, 32'h0000_0100, fetch address on trap entry
IALIGN, 4, sequential increment and required target alignment in bytes (2 or 4 only)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit hold; 1 = keep pc
redirect_valid  in  1  taken branch/jump resolved in EX
redirect_target  in  XLEN  branch/jump target
trap_valid  in  1  exception/interrupt request
mret_valid  in  1  return from trap
halt_req  in  1  debug halt request
resume  in  1  leave HALTED
pc  out  XLEN  current fetch address
pc_plus  out  XLEN  pc + IALIGN (combinational)
pc_valid  out  1  pc is a fetch the pipeline must execute
flush  out  1  one-cycle pulse: squash younger IF/ID contents
epc  out  XLEN  PC saved on trap entry
mtval  out  XLEN  offending target on misalignment trap, else 0 on trap
misalign  out  1  one-cycle pulse: redirect target misaligned
halted  out  1  1 while in HALTED

Behaviour:
- Reset (reset=1 at edge): state=BOOT, pc=RESET_VECTOR, pc_valid=0, flush=0, misalign=0, epc=0, mtval=0, halted=0. Reset wins over every other input, in any state.
- BOOT: lasts exactly one cycle; pc unchanged, pc_valid=0; then RUN.
- RUN: pc_valid=1. Next-pc priority, highest first:
  1. trap_valid: pc<=TRAP_VECTOR, epc<=pc, mtval<=0, flush=1.
  2. redirect_valid with redirect_target[log2(IALIGN)-1:0]!=0: treated as a trap. pc<=TRAP_VECTOR, epc<=pc, mtval<=redirect_target, misalign=1, flush=1.
  3. mret_valid: pc<=epc, flush=1.
  4. redirect_valid (aligned): pc<=redirect_target, flush=1.
  5. halt_req: pc held, state<=HALTED.
  6. stall: pc held.
  7. otherwise: pc<=pc_plus.
- Items 1-4 override stall; a redirect is never lost to a concurrent stall.
- halt_req together with a redirect or trap: the redirect or trap takes effect and the halt is taken on a later cycle, provided halt_req is still high.
- HALTED:
  - pc held, pc_valid=0, halted=1.
  - resume: state<=RUN next cycle, fetch continues from the held pc.
  - trap_valid: handled as rule 1 and state<=RUN.
  - redirect_valid and mret_valid are ignored.
- flush and misalign are registered pulses, high in the cycle after the causing edge, concurrent with the new pc.
- Arithmetic: pc_plus = pc + IALIGN modulo 2^XLEN. 2^XLEN-IALIGN wraps to 0 with no flag.
- epc and mtval change only on trap entry.
- IALIGN other than 2 or 4: elaboration error.
- Latency: one cycle from any request to the updated pc.

Test Plan:
- Reset, then stall=0 for 4 cycles -> pc 0x0 (pc_valid=0, BOOT), then 0x0, 0x4, 0x8, 0xC with pc_valid=1.
- At pc=0x10, stall=1 for 3 cycles, then redirect_valid=1, target=0x200, with stall still 1 -> pc holds 0x10 for 3 cycles, then 0x200 with flush=1 for one cycle.
- At pc=0x40, redirect_valid=1 with target=0x202 (IALIGN=4) -> pc=0x100, epc=0x40, mtval=0x202, misalign=1, flush=1.
- Sequence:
  - At pc=0x80, trap_valid=1 and redirect_valid=1 -> pc=0x100, epc=0x80.
  - Later mret_valid=1 -> pc=0x80, flush=1.
- At pc=0x20, halt_req=1 for 1 cycle -> halted=1, pc_valid=0, pc stays 0x20 for 5 cycles; resume=1 -> pc 0x20 then 0x24 with pc_valid=1.
- Load pc=0xFFFF_FFF8 by redirect, run 3 cycles -> 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Then assert reset mid-run -> pc=RESET_VECTOR, pc_valid=0 for one cycle.
